// File: rtl/lector_pkg.sv
// Shared types and defaults for the output-FIFO reader lector_salida.
package lector_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 10;
   localparam int unsigned CNT_WIDTH_DEF  = 8;
   localparam int unsigned PORT_W         = 2;
   localparam int unsigned NUM_PORTS      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/lector_salida_rr_sel4.sv
// Four-way round-robin arbiter: the search starts one past the last served port and wraps.
module rr_sel4
   import lector_pkg::*;
(
   input  logic [3:0]        request,
   input  logic [PORT_W-1:0] last,
   output logic [3:0]        grant,
   output logic [PORT_W-1:0] grant_idx
);

   // First requester at or after last+1, searching upward with wrap.
   always_comb begin
      logic              found;
      logic [PORT_W-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
         idx = last + PORT_W'(i);
         if (!found && request[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/lector_salida.sv
// Reader of four output FIFOs that drains them round-robin into one valid/ready port.
// Optional per-port delivered-word counters are built when LECTOR_CNT_EN is defined.
module lector_salida
   import lector_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  empty_p0,
   input  logic                  empty_p1,
   input  logic                  empty_p2,
   input  logic                  empty_p3,
   input  logic [DATA_WIDTH-1:0] data_in0,
   input  logic [DATA_WIDTH-1:0] data_in1,
   input  logic [DATA_WIDTH-1:0] data_in2,
   input  logic [DATA_WIDTH-1:0] data_in3,
   input  logic                  ready,
   output logic                  pop_p0,
   output logic                  pop_p1,
   output logic                  pop_p2,
   output logic                  pop_p3,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic [PORT_W-1:0]     port_out,
   output logic [CNT_WIDTH-1:0]  cnt_p0,
   output logic [CNT_WIDTH-1:0]  cnt_p1,
   output logic [CNT_WIDTH-1:0]  cnt_p2,
   output logic [CNT_WIDTH-1:0]  cnt_p3
);

   state_e                state_q, state_d;
   logic [PORT_W-1:0]     last_q, last_d;
   logic [PORT_W-1:0]     pend_q, pend_d;
   logic [PORT_W-1:0]     port_q, port_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] cap_data;
   logic [3:0]            request;
   logic [3:0]            grant;
   logic [PORT_W-1:0]     grant_idx;
   logic                  pop_en;

   assign request = ~{empty_p3, empty_p2, empty_p1, empty_p0};

   rr_sel4 u_rr_sel4 (
      .request   (request),
      .last      (last_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Read-data mux for the port popped in the previous cycle.
   always_comb begin
      case (pend_q)
         2'd0:    cap_data = data_in0;
         2'd1:    cap_data = data_in1;
         2'd2:    cap_data = data_in2;
         default: cap_data = data_in3;
      endcase
   end

   // Next-state, pop and output-register logic.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      pend_d  = pend_q;
      port_d  = port_q;
      data_d  = data_q;
      valid_d = valid_q;
      pop_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|request) begin
               pop_en  = 1'b1;
               state_d = CAPT;
            end
         end
         CAPT: begin
            data_d  = cap_data;
            port_d  = pend_q;
            valid_d = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (ready) begin
               valid_d = 1'b0;
               if (|request) begin
                  pop_en  = 1'b1;
                  state_d = CAPT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A pop must never escape while reset is held.
      if (reset) pop_en = 1'b0;
      if (pop_en) begin
         last_d = grant_idx;
         pend_d = grant_idx;
      end
   end

   assign {pop_p3, pop_p2, pop_p1, pop_p0} = grant & {4{pop_en}};

   // State and output registers; reset drops any word in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= PORT_W'(3);
         pend_q  <= '0;
         port_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         pend_q  <= pend_d;
         port_q  <= port_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign port_out  = port_q;

`ifdef LECTOR_CNT_EN
   logic                 xfer;
   logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];
   logic [CNT_WIDTH-1:0] cnt_d [NUM_PORTS];

   assign xfer = (state_q == HOLD) && ready;

   // Saturating count of words delivered per source port.
   always_comb begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (xfer && (port_q == PORT_W'(i)) && (cnt_q[i] != '1))
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (reset) cnt_q[i] <= '0;
         else       cnt_q[i] <= cnt_d[i];
      end
   end

   assign cnt_p0 = cnt_q[0];
   assign cnt_p1 = cnt_q[1];
   assign cnt_p2 = cnt_q[2];
   assign cnt_p3 = cnt_q[3];
`else
   assign cnt_p0 = '0;
   assign cnt_p1 = '0;
   assign cnt_p2 = '0;
   assign cnt_p3 = '0;
`endif

endmodule

// File: tb/tb_lector_salida.sv
// Bench for lector_salida: FIFO models, round-robin reference, scoreboard and directed corners.
module tb_lector_salida;

   localparam int unsigned DW = 10;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    emp;
   logic [DW-1:0] din [4];
   logic          ready;
   logic          pop_p0, pop_p1, pop_p2, pop_p3;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic [1:0]    port_out;
   logic [CW-1:0] cnt_p0, cnt_p1, cnt_p2, cnt_p3;

   lector_salida #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .empty_p0(emp[0]), .empty_p1(emp[1]), .empty_p2(emp[2]), .empty_p3(emp[3]),
      .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
      .ready(ready),
      .pop_p0(pop_p0), .pop_p1(pop_p1), .pop_p2(pop_p2), .pop_p3(pop_p3),
      .data_out(data_out), .valid_out(valid_out), .port_out(port_out),
      .cnt_p0(cnt_p0), .cnt_p1(cnt_p1), .cnt_p2(cnt_p2), .cnt_p3(cnt_p3)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    port;
      logic [DW-1:0] data;
      int            cyc;
   } sb_t;

   typedef struct {
      int            port;
      logic [DW-1:0] data;
   } vec_t;

   logic [DW-1:0] fq [4][$];
   sb_t           sb [$];
   int            xfer_ports [$];
   logic [DW-1:0] xfer_data [$];
   int            xfer_cyc [$];
   int            exp_cnt [4];
   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            tb_last = 3;
   int            pend_idx = 0;
   bit            pend_valid = 1'b0;
   bit            valid_prev = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] rr_exp(input int last, input logic [3:0] req);
      for (int k = 1; k <= 4; k++) begin
         int p;
         p = (last + k) % 4;
         if (req[p]) return 4'(1 << p);
      end
      return 4'b0000;
   endfunction

   task automatic refresh();
      for (int i = 0; i < 4; i++) emp[i] = (fq[i].size() == 0);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // FIFO model: a pop seen before the edge returns its word just after the edge.
   always @(posedge clk) begin
      #1;
      if (pend_valid) begin
         din[pend_idx] = fq[pend_idx].pop_front();
         pend_valid = 1'b0;
      end
      refresh();
   end

   // Monitor: round-robin pop reference, scoreboard, latency and hold stability.
   always @(negedge clk) begin
      logic [3:0] pops, req, expg;
      sb_t        ent;
      cyc++;
      pops = {pop_p3, pop_p2, pop_p1, pop_p0};
      req  = ~emp;
      if (reset) begin
         chk("pop_in_reset", 32'(pops), 32'h0);
         sb.delete();
         tb_last    = 3;
         pend_valid = 1'b0;
         for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
         valid_prev = 1'b0;
      end else begin
         if (valid_out) begin
            if (sb.size() == 0) begin
               chk("word_without_pop", 32'(sb.size()), 32'h1);
            end else begin
               chk("data_out", 32'(data_out), 32'(sb[0].data));
               chk("port_out", 32'(port_out), 32'(sb[0].port));
               if (!valid_prev) chk("pop_to_valid_latency", 32'(cyc - sb[0].cyc), 32'd2);
            end
            if (!ready) begin
               chk("pop_while_holding", 32'(pops), 32'h0);
            end else begin
               xfer_ports.push_back(int'(port_out));
               xfer_data.push_back(data_out);
               xfer_cyc.push_back(cyc);
               if (sb.size() != 0) void'(sb.pop_front());
`ifdef LECTOR_CNT_EN
               if (exp_cnt[port_out] < 3) exp_cnt[port_out]++;
`endif
            end
         end
         if (pops != 4'b0000) begin
            expg = rr_exp(tb_last, req);
            chk("pop_select", 32'(pops), 32'(expg));
            for (int k = 0; k < 4; k++) begin
               if (expg[k]) begin
                  ent.port = 2'(k);
                  ent.data = fq[k][0];
                  ent.cyc  = cyc;
                  sb.push_back(ent);
                  pend_idx   = k;
                  pend_valid = 1'b1;
                  tb_last    = k;
               end
            end
         end
         valid_prev = valid_out;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
   endtask

   task automatic wait_xfers(input int n, input int budget);
      int target;
      int b;
      target = xfer_ports.size() + n;
      b = budget;
      while (xfer_ports.size() < target && b > 0) begin
         cycles(1);
         b--;
      end
      if (xfer_ports.size() < target) chk("xfer_timeout", 32'(xfer_ports.size()), 32'(target));
   endtask

   task automatic wait_idle(input int budget);
      int  b;
      bit  busy;
      b = budget;
      busy = 1'b1;
      while (busy && b > 0) begin
         busy = valid_out || (sb.size() != 0);
         for (int i = 0; i < 4; i++) if (fq[i].size() != 0) busy = 1'b1;
         if (busy) cycles(1);
         b--;
      end
      if (busy) chk("idle_timeout", 32'h1, 32'h0);
   endtask

   task automatic check_cnts();
      chk("cnt_p0", 32'(cnt_p0), 32'(exp_cnt[0]));
      chk("cnt_p1", 32'(cnt_p1), 32'(exp_cnt[1]));
      chk("cnt_p2", 32'(cnt_p2), 32'(exp_cnt[2]));
      chk("cnt_p3", 32'(cnt_p3), 32'(exp_cnt[3]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [5];
      int   s;
      int   b;
      vecs[0] = '{2, 10'h2A5};
      vecs[1] = '{0, 10'h001};
      vecs[2] = '{3, 10'h3FF};
      vecs[3] = '{1, 10'h155};
      vecs[4] = '{2, 10'h000};

      for (int i = 0; i < 4; i++) begin
         din[i] = '0;
         exp_cnt[i] = 0;
      end
      reset = 1'b1;
      ready = 1'b0;
      refresh();
      cycles(3);
      chk("reset_valid_out", 32'(valid_out), 32'h0);
      chk("reset_data_out", 32'(data_out), 32'h0);
      chk("reset_port_out", 32'(port_out), 32'h0);
      chk("reset_pops", 32'({pop_p3, pop_p2, pop_p1, pop_p0}), 32'h0);
      reset = 1'b0;
      cycles(1);
      check_cnts();

      // Single words from one port at a time.
      ready = 1'b1;
      foreach (vecs[v]) begin
         fq[vecs[v].port].push_back(vecs[v].data);
         refresh();
         s = xfer_ports.size();
         wait_xfers(1, 20);
         if (xfer_ports.size() > s) begin
            chk("vec_port", 32'(xfer_ports[s]), 32'(vecs[v].port));
            chk("vec_data", 32'(xfer_data[s]), 32'(vecs[v].data));
         end
         wait_idle(20);
      end
      cycles(1);
      check_cnts();

      // Two words in every FIFO: strict rotation at one word per two cycles.
      do_reset();
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 4; p++) fq[p].push_back(DW'(16 * p + k + 1));
      refresh();
      s = xfer_ports.size();
      wait_xfers(8, 60);
      if (xfer_ports.size() >= s + 8) begin
         for (int k = 0; k < 8; k++) chk("rr_order", 32'(xfer_ports[s + k]), 32'(k % 4));
         chk("throughput_span", 32'(xfer_cyc[s + 7] - xfer_cyc[s]), 32'd14);
      end
      wait_idle(20);

      // Backpressure: word held five cycles, then transfer with same-cycle pop.
      ready = 1'b0;
      fq[0].push_back(10'h1C3);
      fq[1].push_back(10'h0E7);
      refresh();
      b = 10;
      while (!valid_out && b > 0) begin
         cycles(1);
         b--;
      end
      chk("hold_valid", 32'(valid_out), 32'h1);
      cycles(5);
      chk("hold_no_pop", 32'({pop_p3, pop_p2, pop_p1, pop_p0}), 32'h0);
      chk("hold_data", 32'(data_out), 32'h1C3);
      chk("hold_port", 32'(port_out), 32'h0);
      ready = 1'b1;
      #1;
      chk("release_pop", 32'({pop_p3, pop_p2, pop_p1, pop_p0}), 32'b0010);
      wait_idle(20);

      // Reset while a word is being captured.
      fq[3].push_back(10'h0AB);
      refresh();
      cycles(1);
      reset = 1'b1;
      #1;
      chk("capt_reset_pops", 32'({pop_p3, pop_p2, pop_p1, pop_p0}), 32'h0);
      cycles(1);
      chk("capt_reset_valid", 32'(valid_out), 32'h0);
      chk("capt_reset_data", 32'(data_out), 32'h0);
      fq[1].push_back(10'h111);
      fq[0].push_back(10'h100);
      refresh();
      #1;
      chk("reset_requests_no_pop", 32'({pop_p3, pop_p2, pop_p1, pop_p0}), 32'h0);
      cycles(1);
      reset = 1'b0;
      s = xfer_ports.size();
      wait_xfers(2, 30);
      if (xfer_ports.size() >= s + 2) begin
         chk("post_reset_first", 32'(xfer_ports[s]), 32'h0);
         chk("post_reset_first_data", 32'(xfer_data[s]), 32'h100);
         chk("post_reset_second", 32'(xfer_ports[s + 1]), 32'h1);
      end
      wait_idle(20);

      // Five words from p1 against a two-bit counter.
      do_reset();
      for (int k = 0; k < 5; k++) fq[1].push_back(DW'(10'h200 + k));
      refresh();
      wait_xfers(5, 40);
      wait_idle(20);
      cycles(2);
      check_cnts();
`ifdef LECTOR_CNT_EN
      chk("sat_cnt_p1", 32'(cnt_p1), 32'd3);
`else
      chk("sat_cnt_p1", 32'(cnt_p1), 32'd0);
`endif
      chk("sat_cnt_p0", 32'(cnt_p0), 32'd0);
      chk("sat_cnt_p2", 32'(cnt_p2), 32'd0);
      chk("sat_cnt_p3", 32'(cnt_p3), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lector_salida.md
LECTOR_SALIDA -- requirements
Module: lector_salida

Interface
REQ-001 Parameter DATA_WIDTH, default 10, SHALL set the word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the destination field.
REQ-002 Parameter CNT_WIDTH, default 8, SHALL set the per-port counter width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be exactly these, in this order:
 clk  in  1  clock, all state updates on rising edge
 reset  in  1  synchronous active-high reset
 empty_p0..empty_p3  in  1 each  output-FIFO empty flags
 data_in0..data_in3  in  DATA_WIDTH each  output-FIFO read data, valid the cycle after pop
 ready  in  1  downstream accepts data_out this cycle
 pop_p0..pop_p3  out  1 each  read strobe to output FIFOs
 data_out  out  DATA_WIDTH  registered word
 valid_out  out  1  data_out holds a word
 port_out  out  2  index of the FIFO that supplied data_out
 cnt_p0..cnt_p3  out  CNT_WIDTH each  words delivered per port

Function
REQ-005 The block SHALL be the reader of the four output FIFOs, draining them toward one downstream valid/ready port.
REQ-006 The FSM SHALL have states IDLE, CAPT and HOLD.
REQ-007 In IDLE with at least one empty_pN low, the block SHALL assert exactly one pop_pN for one cycle and go to CAPT; otherwise it SHALL stay in IDLE with all pops low.
REQ-008 In CAPT, the block SHALL load data_inN of the popped port into data_out, set port_out=N and valid_out=1 on the next edge, and go to HOLD; no pop SHALL be asserted in CAPT.
REQ-009 In HOLD, valid_out, data_out and port_out SHALL stay stable while ready=0.
REQ-010 In HOLD with ready=1, the word SHALL transfer. If any FIFO is non-empty, one pop SHALL be asserted in that same cycle and the next state SHALL be CAPT; otherwise the next state SHALL be IDLE. In both cases valid_out SHALL be 0 next cycle.
REQ-011 Sustained throughput SHALL be one word per 2 cycles with ready held at 1.
REQ-012 Port selection SHALL be round-robin. Priority starts at (last_served+1) mod 4 and searches upward with wrap; last_served updates when a pop is issued.
REQ-013 At most one pop SHALL be outstanding. At most one pop_pN SHALL be high in any cycle.
REQ-014 pop_pN SHALL be combinational from state, empty flags and ready, and SHALL be forced low while reset=1.
REQ-015 No pop SHALL be issued to a port whose empty flag is high in that cycle.

Reset
REQ-016 On reset, the block SHALL set state=IDLE, last_served=3 (port 0 first), valid_out=0, data_out=0, port_out=0 and all counters=0.
REQ-017 Reset asserted in CAPT or HOLD SHALL discard the in-flight word; the word is lost and no recovery is required.

Configuration
REQ-018 With macro LECTOR_CNT_EN defined, cnt_pN SHALL increment by 1 on each transfer with port_out=N and saturate at all-ones.
REQ-019 Without LECTOR_CNT_EN, cnt_p0..cnt_p3 SHALL be tied to 0 and no counter flops SHALL exist; the ports remain present.

Structure
REQ-020 Package lector_pkg SHALL hold the state encoding (IDLE=0, CAPT=1, HOLD=2), DATA_WIDTH/CNT_WIDTH defaults and the port-index width.
REQ-021 Round-robin selection SHALL be a sub-module rr_sel4: inputs request[3:0] and last[1:0]; outputs grant[3:0] (one-hot) and grant_idx[1:0].

Verification
REQ-022 Only p2 non-empty with data 0x2A5, ready=1 -> pop_p2 at T, valid_out=1 at T+2 with data_out=0x2A5, port_out=2.
REQ-023 All four FIFOs hold 2 words each, ready=1 -> service order 0,1,2,3,0,1,2,3, with one transfer every 2 cycles.
REQ-024 Word held in HOLD, ready=0 for 5 cycles -> data_out stable, no pop asserted; ready=1 -> transfer plus same-cycle next pop.
REQ-025 reset pulsed in CAPT -> valid_out=0, state IDLE, all pops low during reset; next service starts at port 0.
REQ-026 With LECTOR_CNT_EN and CNT_WIDTH=2, 5 transfers from p1 -> cnt_p1=3 (saturated), others 0; without the macro -> all counters 0.
